// File: rtl/nios_debug_ocimem_sequencer_if.sv
// OCI RAM port bundle between the debug sequencer and the on-chip debug memory.
//   master (sequencer): drives mem_req/mem_we/mem_addr/mem_wdata, samples mem_ack/mem_rdata
//   slave  (memory)   : samples the request, returns mem_ack/mem_rdata
// mem_ack completes a request in the same cycle it is seen high.
interface nios_debug_ocimem_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/nios_debug_ocimem_sequencer.sv
// Debug-slave OCI memory sequencer (clk domain).
// Turns synchronised JTAG commands (cmd_valid + ir_in + jdo) into single
// request/acknowledge accesses on the OCI RAM port, with a word address that
// auto-increments after each completed access and a timeout on mem_ack.
// Ports:
//   clk, reset_n        : system clock, synchronous active-low reset
//   cmd_valid           : one-cycle pulse, ir_in/jdo hold a new command
//   ir_in[1:0]          : only 2'b00 (ocimem) commands are decoded
//   jdo[37:0]           : [37:36] opcode, [31:0] data / address
//   mem                 : OCI RAM port (master side)
//   MonDReg[31:0]       : last read data
//   monitor_ready       : idle, can take a command
//   monitor_error       : sticky timeout/overrun flag
//   busy                : transaction in flight (inverse of monitor_ready)
module nios_debug_ocimem_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                cmd_valid,
    input  logic [1:0]                          ir_in,
    input  logic [37:0]                         jdo,
    nios_debug_ocimem_sequencer_if.master       mem,
    output logic [31:0]                         MonDReg,
    output logic                                monitor_ready,
    output logic                                monitor_error,
    output logic                                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_CTRL     = 2'b00,
        OP_SET_ADDR = 2'b01,
        OP_WRITE    = 2'b10,
        OP_READ     = 2'b11
    } opcode_t;

    // Timer value on the last WAIT cycle allowed before aborting.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [15:0]       timer_q,   timer_d;
    logic              req_q,     req_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] maddr_q,   maddr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [31:0]       mondreg_q, mondreg_d;
    logic              ready_q,   ready_d;
    logic              error_q,   error_d;

    logic    cmd_ocimem;
    opcode_t opcode;

    // jdo[35:32] carry no meaning for any opcode.
    logic unused_jdo;
    assign unused_jdo = ^jdo[35:32];

    assign cmd_ocimem = cmd_valid && (ir_in == 2'b00);
    assign opcode     = opcode_t'(jdo[37:36]);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        req_d     = req_q;
        we_d      = we_q;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        mondreg_d = mondreg_q;
        ready_d   = ready_q;
        error_d   = error_q;

        case (state_q)
            IDLE: begin
                if (cmd_ocimem) begin
                    case (opcode)
                        OP_CTRL: begin
                            if (jdo[0]) error_d = 1'b0;
                        end
                        OP_SET_ADDR: begin
                            addr_d = jdo[ADDR_W-1:0];
                        end
                        OP_WRITE, OP_READ: begin
                            if (opcode == OP_WRITE) wdata_d = jdo[31:0];
                            we_d    = (opcode == OP_WRITE);
                            state_d = ISSUE;
                            req_d   = 1'b1;
                            maddr_d = addr_q;
                            timer_d = '0;
                            ready_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            // An ack already present in ISSUE completes the access just as in WAIT.
            ISSUE, WAIT: begin
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    if (!we_q) mondreg_d = mem.mem_rdata;
                    addr_d  = addr_q + 1'b1;
                    state_d = DONE;
                end else if (state_q == ISSUE) begin
                    state_d = WAIT;
                end else if (timer_q == TMO_LAST) begin
                    // Abort: address and MonDReg keep their old values.
                    req_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Overrun: command arriving while not idle is dropped but flagged.
        // This also covers a CTRL clear issued while busy.
        if (cmd_ocimem && (state_q != IDLE)) error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            mondreg_q <= '0;
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            we_q      <= we_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            mondreg_q <= mondreg_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;
    assign MonDReg       = mondreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign busy          = ~ready_q;

endmodule

// File: tb/tb_nios_debug_ocimem_sequencer.sv
// Directed bench for nios_debug_ocimem_sequencer with ADDR_W=8, TIMEOUT_CYC=4.
module tb_nios_debug_ocimem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [1:0]  ir_in;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    nios_debug_ocimem_sequencer_if #(.ADDR_W(8)) mif ();

    nios_debug_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .ir_in         (ir_in),
        .jdo           (jdo),
        .mem           (mif),
        .MonDReg       (MonDReg),
        .monitor_ready (monitor_ready),
        .monitor_error (monitor_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] ir, input logic [37:0] j);
        cmd_valid = 1'b1;
        ir_in     = ir;
        jdo       = j;
        tick();
        cmd_valid = 1'b0;
        ir_in     = 2'b00;
        jdo       = '0;
    endtask

    function automatic logic [37:0] mk(input logic [1:0] op, input logic [31:0] d);
        return {op, 4'h0, d};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; ir_in = 2'b00; jdo = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mif.mem_req); end
        checks++; if (mif.mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", mif.mem_addr); end
        checks++; if (MonDReg !== 32'h0) begin failures++; $display("FAIL reset_mondreg got=%h exp=0", MonDReg); end
        checks++; if ({monitor_ready, monitor_error, busy} !== 3'b100) begin failures++; $display("FAIL reset_status got=%b exp=100", {monitor_ready, monitor_error, busy}); end
    endtask

    task automatic test_write();
        send_cmd(2'b00, mk(2'b01, 32'h10));
        checks++; if (monitor_ready !== 1'b1) begin failures++; $display("FAIL setaddr_ready got=%b exp=1", monitor_ready); end
        send_cmd(2'b00, mk(2'b10, 32'hDEADBEEF));       // cycle 1: ISSUE
        checks++; if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata} !== {1'b1, 1'b1, 8'h10, 32'hDEADBEEF})
            begin failures++; $display("FAIL wr_issue got=%b%b %h %h exp=11 10 deadbeef", mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
        tick();                                           // cycle 2: WAIT1
        tick();                                           // cycle 3: WAIT2
        checks++; if ({mif.mem_req, mif.mem_addr, mif.mem_wdata} !== {1'b1, 8'h10, 32'hDEADBEEF})
            begin failures++; $display("FAIL wr_hold got=%b %h %h exp=1 10 deadbeef", mif.mem_req, mif.mem_addr, mif.mem_wdata); end
        mif.mem_ack = 1'b1;
        tick();                                           // cycle 4: DONE
        mif.mem_ack = 1'b0;
        checks++; if ({mif.mem_req, monitor_ready} !== 2'b00) begin failures++; $display("FAIL wr_done got=%b exp=00", {mif.mem_req, monitor_ready}); end
        tick();                                           // cycle 5
        checks++; if (monitor_ready !== 1'b1) begin failures++; $display("FAIL wr_ready5 got=%b exp=1", monitor_ready); end
        // Address advanced to 0x11: a read must present it.
        send_cmd(2'b00, mk(2'b11, 32'h0));
        checks++; if (mif.mem_addr !== 8'h11) begin failures++; $display("FAIL wr_incr got=%h exp=11", mif.mem_addr); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0BAD0BAD;
        tick(); mif.mem_ack = 1'b0; tick();
    endtask

    task automatic test_read();
        send_cmd(2'b00, mk(2'b01, 32'h10));
        send_cmd(2'b00, mk(2'b11, 32'h0));              // cycle 1: ISSUE
        checks++; if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {1'b1, 1'b0, 8'h10})
            begin failures++; $display("FAIL rd_issue got=%b%b %h exp=10 10", mif.mem_req, mif.mem_we, mif.mem_addr); end
        tick();                                           // cycle 2: WAIT1
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h12345678;
        tick();                                           // cycle 3: DONE
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'hFFFFFFFF;
        checks++; if (MonDReg !== 32'h12345678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", MonDReg); end
        checks++; if (monitor_ready !== 1'b0) begin failures++; $display("FAIL rd_ready3 got=%b exp=0", monitor_ready); end
        tick();                                           // cycle 4
        checks++; if ({monitor_ready, monitor_error} !== 2'b10) begin failures++; $display("FAIL rd_ready4 got=%b exp=10", {monitor_ready, monitor_error}); end
        // Ack already present in the ISSUE cycle is honoured; address is now 0x11.
        send_cmd(2'b00, mk(2'b11, 32'h0));
        checks++; if (mif.mem_addr !== 8'h11) begin failures++; $display("FAIL rd_incr got=%h exp=11", mif.mem_addr); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
        tick();
        mif.mem_ack = 1'b0;
        checks++; if ({mif.mem_req, MonDReg} !== {1'b0, 32'hCAFEF00D}) begin failures++; $display("FAIL rd_issue_ack got=%b %h exp=0 cafef00d", mif.mem_req, MonDReg); end
        tick();
    endtask

    task automatic test_wrap();
        send_cmd(2'b00, mk(2'b01, 32'hFF));
        send_cmd(2'b00, mk(2'b11, 32'h0));
        checks++; if (mif.mem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_first got=%h exp=ff", mif.mem_addr); end
        tick(); mif.mem_ack = 1'b1; mif.mem_rdata = 32'hAAAA0001;
        tick(); mif.mem_ack = 1'b0; tick();
        send_cmd(2'b00, mk(2'b11, 32'h0));
        checks++; if (mif.mem_addr !== 8'h00) begin failures++; $display("FAIL wrap_second got=%h exp=00", mif.mem_addr); end
        tick(); mif.mem_ack = 1'b1; mif.mem_rdata = 32'hAAAA0002;
        tick(); mif.mem_ack = 1'b0; tick();
        checks++; if (MonDReg !== 32'hAAAA0002) begin failures++; $display("FAIL wrap_data got=%h exp=aaaa0002", MonDReg); end
    endtask

    task automatic test_timeout();
        // Address is 0x01 after the wrap reads.
        mif.mem_rdata = 32'h99999999;
        send_cmd(2'b00, mk(2'b11, 32'h0));               // ISSUE
        checks++; if (mif.mem_addr !== 8'h01) begin failures++; $display("FAIL tmo_addr got=%h exp=01", mif.mem_addr); end
        tick(); tick(); tick(); tick();                   // WAIT1..WAIT4
        checks++; if (mif.mem_req !== 1'b1) begin failures++; $display("FAIL tmo_wait4_req got=%b exp=1", mif.mem_req); end
        tick();                                           // DONE
        checks++; if ({mif.mem_req, monitor_error} !== 2'b01) begin failures++; $display("FAIL tmo_abort got=%b exp=01", {mif.mem_req, monitor_error}); end
        tick();
        checks++; if ({monitor_ready, MonDReg} !== {1'b1, 32'hAAAA0002}) begin failures++; $display("FAIL tmo_mondreg got=%b %h exp=1 aaaa0002", monitor_ready, MonDReg); end
        send_cmd(2'b00, mk(2'b00, 32'h1));
        checks++; if (monitor_error !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", monitor_error); end
        send_cmd(2'b00, mk(2'b11, 32'h0));
        checks++; if (mif.mem_addr !== 8'h01) begin failures++; $display("FAIL tmo_addr_kept got=%h exp=01", mif.mem_addr); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h55550001;
        tick(); mif.mem_ack = 1'b0; tick();              // addr -> 0x02
    endtask

    task automatic test_overrun();
        send_cmd(2'b00, mk(2'b10, 32'h11112222));        // ISSUE, addr 0x02
        tick();                                           // WAIT1
        send_cmd(2'b00, mk(2'b10, 32'h33334444));        // dropped; now WAIT2
        checks++; if ({monitor_error, mif.mem_req, mif.mem_wdata, mif.mem_addr} !== {1'b1, 1'b1, 32'h11112222, 8'h02})
            begin failures++; $display("FAIL ovr_inflight got=%b%b %h %h exp=11 11112222 02", monitor_error, mif.mem_req, mif.mem_wdata, mif.mem_addr); end
        mif.mem_ack = 1'b1;
        tick(); mif.mem_ack = 1'b0; tick();              // IDLE
        tick();
        checks++; if ({mif.mem_req, monitor_ready, monitor_error} !== 3'b011) begin failures++; $display("FAIL ovr_no_second got=%b exp=011", {mif.mem_req, monitor_ready, monitor_error}); end
        send_cmd(2'b00, mk(2'b00, 32'h1));
        // Non-ocimem IR: neither SET_ADDR nor READ may act.
        send_cmd(2'b01, mk(2'b01, 32'h33));
        send_cmd(2'b01, mk(2'b11, 32'h0));
        checks++; if ({mif.mem_req, monitor_ready, monitor_error} !== 3'b010) begin failures++; $display("FAIL ir01_ignored got=%b exp=010", {mif.mem_req, monitor_ready, monitor_error}); end
        send_cmd(2'b00, mk(2'b11, 32'h0));
        checks++; if (mif.mem_addr !== 8'h03) begin failures++; $display("FAIL ir01_addr got=%h exp=03", mif.mem_addr); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h77778888;
        tick(); mif.mem_ack = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        send_cmd(2'b00, mk(2'b11, 32'h0));               // ISSUE
        tick();                                           // WAIT1
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if ({mif.mem_req, monitor_ready, busy, monitor_error} !== 4'b0100) begin failures++; $display("FAIL rst_mid_status got=%b exp=0100", {mif.mem_req, monitor_ready, busy, monitor_error}); end
        checks++; if (MonDReg !== 32'h0) begin failures++; $display("FAIL rst_mid_mondreg got=%h exp=0", MonDReg); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBEEFBEEF;  // late ack in IDLE
        tick();
        mif.mem_ack = 1'b0;
        checks++; if ({mif.mem_req, MonDReg} !== {1'b0, 32'h0}) begin failures++; $display("FAIL rst_late_ack got=%b %h exp=0 0", mif.mem_req, MonDReg); end
        send_cmd(2'b00, mk(2'b11, 32'h0));
        checks++; if (mif.mem_addr !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", mif.mem_addr); end
        mif.mem_ack = 1'b1;
        tick(); mif.mem_ack = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
